// File: rtl/circuit1_seq_ctrl.sv
// Multi-cycle Circuit1 datapath: one shared add/sub unit and one multiplier,
// sequenced IDLE -> S_D -> S_E -> S_F -> S_X, with start/busy/done handshake.
module circuit1_seq_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  input  logic [DATA_W-1:0]     c,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     z,
  output logic [2*DATA_W-1:0]   x
);

  localparam int XW = 2 * DATA_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S_D  = 3'd1,
    S_E  = 3'd2,
    S_F  = 3'd3,
    S_X  = 3'd4
  } state_t;

  state_t state_r;
  state_t next_state_s;

  logic [DATA_W-1:0] ra_r;
  logic [DATA_W-1:0] rb_r;
  logic [DATA_W-1:0] rc_r;
  logic [DATA_W-1:0] d_r;
  logic [DATA_W-1:0] e_r;
  logic [XW-1:0]     f_r;
  logic              g_r;
  logic              busy_r;
  logic              done_r;
  logic [DATA_W-1:0] z_r;
  logic [XW-1:0]     x_r;

  logic              cap_s;
  logic              ld_d_s;
  logic              ld_e_s;
  logic              ld_fg_s;
  logic              ld_xz_s;
  logic              alu_sub_s;
  logic [XW-1:0]     alu_a_s;
  logic [XW-1:0]     alu_b_s;
  logic [XW-1:0]     alu_y_s;
  logic [XW-1:0]     mul_y_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: every non-IDLE state lasts exactly one cycle
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = S_D;
        end else begin
          next_state_s = IDLE;
        end
      end
      S_D:     next_state_s = S_E;
      S_E:     next_state_s = S_F;
      S_F:     next_state_s = S_X;
      S_X:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Per-state control: load enables and shared ALU operand/mode selection
  always_comb begin
    cap_s     = 1'b0;
    ld_d_s    = 1'b0;
    ld_e_s    = 1'b0;
    ld_fg_s   = 1'b0;
    ld_xz_s   = 1'b0;
    alu_sub_s = 1'b0;
    alu_a_s   = {XW{1'b0}};
    alu_b_s   = {XW{1'b0}};
    case (state_r)
      IDLE: begin
        if (start) begin
          cap_s = 1'b1;
        end else begin
          cap_s = 1'b0;
        end
      end
      S_D: begin
        ld_d_s  = 1'b1;
        alu_a_s = {{DATA_W{1'b0}}, ra_r};
        alu_b_s = {{DATA_W{1'b0}}, rb_r};
      end
      S_E: begin
        ld_e_s  = 1'b1;
        alu_a_s = {{DATA_W{1'b0}}, ra_r};
        alu_b_s = {{DATA_W{1'b0}}, rc_r};
      end
      S_F: begin
        ld_fg_s = 1'b1;
      end
      S_X: begin
        ld_xz_s   = 1'b1;
        alu_sub_s = 1'b1;
        alu_a_s   = f_r;
        alu_b_s   = {{DATA_W{1'b0}}, d_r};
      end
      default: begin
        cap_s = 1'b0;
      end
    endcase
  end

  // Shared add/sub unit; the mode select guarantees one operation per cycle
  always_comb begin
    if (alu_sub_s) begin
      alu_y_s = alu_a_s - alu_b_s;
    end else begin
      alu_y_s = alu_a_s + alu_b_s;
    end
  end

  assign mul_y_s = {{DATA_W{1'b0}}, ra_r} * {{DATA_W{1'b0}}, rc_r};

  // Datapath and output registers; reset discards any partial result
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_r   <= {DATA_W{1'b0}};
      rb_r   <= {DATA_W{1'b0}};
      rc_r   <= {DATA_W{1'b0}};
      d_r    <= {DATA_W{1'b0}};
      e_r    <= {DATA_W{1'b0}};
      f_r    <= {XW{1'b0}};
      g_r    <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      z_r    <= {DATA_W{1'b0}};
      x_r    <= {XW{1'b0}};
    end else begin
      if (cap_s) begin
        ra_r <= a;
        rb_r <= b;
        rc_r <= c;
      end
      if (ld_d_s) begin
        d_r <= alu_y_s[DATA_W-1:0];
      end
      if (ld_e_s) begin
        e_r <= alu_y_s[DATA_W-1:0];
      end
      if (ld_fg_s) begin
        f_r <= mul_y_s;
        g_r <= (d_r > e_r);
      end
      if (ld_xz_s) begin
        x_r <= alu_y_s;
        z_r <= g_r ? d_r : e_r;
      end
      busy_r <= (next_state_s != IDLE);
      done_r <= ld_xz_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign z    = z_r;
  assign x    = x_r;

endmodule

// File: tb/tb_circuit1_seq_ctrl.sv
// Self-checking bench for circuit1_seq_ctrl: cycle-count reference model
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_circuit1_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  c;
  logic        busy;
  logic        done;
  logic [7:0]  z;
  logic [15:0] x;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  circuit1_seq_ctrl #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
    .busy(busy), .done(done), .z(z), .x(x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void calc(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic,
                               output logic [7:0] oz, output logic [15:0] ox);
    logic [7:0]  d;
    logic [7:0]  e;
    logic [15:0] f;
    d  = ia + ib;
    e  = ia + ic;
    f  = 16'(ia) * 16'(ic);
    oz = (d > e) ? d : e;
    ox = f - 16'(d);
  endfunction

  // Reference model: an accepted start produces results four edges later
  int          m_cnt;
  logic        m_busy;
  logic        m_done;
  logic [7:0]  m_z;
  logic [15:0] m_x;
  logic [7:0]  p_z;
  logic [15:0] p_x;

  always @(posedge clk) begin
    logic [7:0]  tz;
    logic [15:0] tx;
    if (rst) begin
      m_cnt  <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_z    <= 8'd0;
      m_x    <= 16'd0;
    end else if (m_cnt == 0 && start) begin
      calc(a, b, c, tz, tx);
      p_z    <= tz;
      p_x    <= tx;
      m_cnt  <= 4;
      m_busy <= 1'b1;
      m_done <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_z    <= p_z;
        m_x    <= p_x;
        m_done <= 1'b1;
        m_busy <= 1'b0;
      end else begin
        m_done <= 1'b0;
        m_busy <= 1'b1;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_done", 32'(done), 32'(m_done));
      chk("model_z", 32'(z), 32'(m_z));
      chk("model_x", 32'(x), 32'(m_x));
    end
  end

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic,
                        input string nm);
    int lat;
    @(negedge clk);
    a = ia; b = ib; c = ic; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd4);
  endtask

  initial begin
    int cnt;
    int first;
    int second;
    rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0; c = 8'd0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    rst = 1'b0;

    // T1 basic
    run_op(8'd3, 8'd4, 8'd5, "t1");
    chk("t1_z", 32'(z), 32'd8);
    chk("t1_x", 32'(x), 32'd8);

    // T2 d wraps
    run_op(8'd200, 8'd100, 8'd10, "t2");
    chk("t2_z", 32'(z), 32'd210);
    chk("t2_x", 32'(x), 32'd1956);

    // T3 equal d/e, x wraps
    run_op(8'd2, 8'd0, 8'd0, "t3");
    chk("t3_z", 32'(z), 32'd2);
    chk("t3_x", 32'(x), 32'd65534);

    // T4 all-ones with start held high: back-to-back acceptance
    @(negedge clk);
    a = 8'd255; b = 8'd255; c = 8'd255; start = 1'b1;
    cnt = 0; first = -1; second = -1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      if (i == 15) start = 1'b0;
    end
    chk("t4_pulses", 32'(cnt), 32'd3);
    chk("t4_first", 32'(first), 32'd5);
    chk("t4_period", 32'(second - first), 32'd5);
    chk("t4_z", 32'(z), 32'd254);
    chk("t4_x", 32'(x), 32'd64771);

    // T5 reset mid-operation
    @(negedge clk);
    a = 8'd10; b = 8'd20; c = 8'd30; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_z", 32'(z), 32'd0);
    chk("t5_x", 32'(x), 32'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("t5_no_done", 32'(cnt), 32'd0);
    run_op(8'd7, 8'd1, 8'd2, "t5b");
    chk("t5b_z", 32'(z), 32'd9);
    chk("t5b_x", 32'(x), 32'd6);

    // T6 start and operand changes while busy are ignored
    @(negedge clk);
    a = 8'd4; b = 8'd5; c = 8'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'd9; b = 8'd9; c = 8'd9;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        if (cnt == 1) begin
          chk("t6_z", 32'(z), 32'd10);
          chk("t6_x", 32'(x), 32'd15);
        end
      end
    end
    chk("t6_pulses", 32'(cnt), 32'd1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
